// File: rtl/irq_encoder_32_5_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_encoder_32_5_if
//  Description : Bundle of request / mask / grant-handshake signals between
//                interrupt sources, the priority encoder and its consumer.
//                slave  : the encoder (takes req/mask/out_ack, drives the rest)
//                master : the consumer/stimulus side
//  Signals     : req[31:0], mask[31:0], out_ack, out_valid, out_idx[4:0],
//                pending[31:0], busy
//  Revision    : 1.0  initial release
// ============================================================================
interface irq_encoder_32_5_if #(
  parameter int REQ_W = 32,
  parameter int IDX_W = 5
);
  logic [REQ_W-1:0] req;
  logic [REQ_W-1:0] mask;
  logic             out_ack;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [REQ_W-1:0] pending;
  logic             busy;

  modport slave (
    input  req, mask, out_ack,
    output out_valid, out_idx, pending, busy
  );

  modport master (
    output req, mask, out_ack,
    input  out_valid, out_idx, pending, busy
  );
endinterface
`default_nettype wire

// File: rtl/irq_encoder_32_5.sv
`default_nettype none
// ============================================================================
//  Module      : irq_encoder_32_5
//  Description : Sequential 32-to-5 priority encoder. Level requests are
//                latched into a pending register; the highest-priority
//                enabled pending line is encoded and held on out_idx until
//                the consumer acknowledges it.
//  Ports       : clk            - clock, rising edge
//                rst            - asynchronous active-high reset
//                bus (slave)    - req, mask, out_ack in;
//                                 out_valid, out_idx, pending, busy out
//  Options     : IRQ_ROUND_ROBIN_EN - rotating priority starting after the
//                last acknowledged index; undefined gives fixed priority
//                with bit 0 highest.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_encoder_32_5 #(
  parameter int REQ_W = 32,
  parameter int IDX_W = 5
) (
  input wire                clk,
  input wire                rst,
  irq_encoder_32_5_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t           r_state;
  logic [REQ_W-1:0] r_pending;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;

  logic [REQ_W-1:0] w_cand;
  logic [REQ_W-1:0] w_clr;
  logic [IDX_W-1:0] w_sel;
  logic             w_any;

  assign w_cand = r_pending & bus.mask;
  assign w_any  = |w_cand;

  // One-hot clear of the presented line, only on an accepted grant.
  always_comb begin
    w_clr = '0;
    if (r_valid && bus.out_ack) begin
      w_clr[r_idx] = 1'b1;
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;

  // Walk from farthest to nearest so the first set bit after r_ptr
  // (wrapping modulo 32) is the final assignment.
  always_comb begin
    w_sel = '0;
    for (int k = REQ_W - 1; k >= 0; k--) begin
      if (w_cand[r_ptr + IDX_W'(1) + IDX_W'(k)]) begin
        w_sel = r_ptr + IDX_W'(1) + IDX_W'(k);
      end
    end
  end
`else
  // Descending scan: the lowest set index is written last and wins.
  always_comb begin
    w_sel = '0;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_sel = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
      r_ptr     <= IDX_W'(REQ_W - 1);
`endif
    end else begin
      // OR-ing req after the clear makes a same-edge set win.
      r_pending <= (r_pending & ~w_clr) | bus.req;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_idx   <= w_sel;
            r_valid <= 1'b1;
            r_state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // Index is frozen here regardless of mask/req/pending changes.
          if (bus.out_ack) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
`ifdef IRQ_ROUND_ROBIN_EN
            r_ptr   <= r_idx;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_idx   = r_idx;
  assign bus.pending   = r_pending;
  assign bus.busy      = r_valid;

endmodule
`default_nettype wire
